axis_master_if: RTL and testbench

Outbound AXI-Stream master that streams computed output activations from the on-chip output memory to the PS/DMA once a compute pass completes. It reads VLW_WDT-wide memory words, unpacks each word MSB-first into M_TDATA_WDT beats, buffers the beats in a small FIFO and drives a registered AXI-Stream master port with full TREADY backpressure. TLAST marks the final beat of the frame. It is the transmit-side counterpart of the inbound slave interface and shares the same busy/done handshake with the controller.

---
 rtl/axis_master_if_pkg.sv | 21 ++
 rtl/axis_master_if_if.sv | 12 +
 rtl/axis_master_if_fifo.sv | 41 ++++
 rtl/axis_master_if.sv | 167 ++++++++++++++++
 tb/tb_axis_master_if.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_master_if_pkg.sv
// Shared parameters for the outbound AXI-Stream master: memory geometry in dnn_pckg,
// stream-side widths and the transmit FSM state type in axi_stream_pckg.
package dnn_pckg;
  localparam int VLW_WDT            = 128;
  localparam int ACTIV_MEM_ADDR_WDT = 8;
endpackage

package axi_stream_pckg;
  import dnn_pckg::*;

  localparam int M_TDATA_WDT     = 32;
  localparam int M_FIFO_ADDR_WDT = 3;
  localparam int WORD_BEATS      = VLW_WDT / M_TDATA_WDT;
  localparam int BEAT_CNT_WDT    = $clog2(WORD_BEATS);

  typedef enum logic [1:0] {
    M_IDLE,
    M_SEND,
    M_DRAIN
  } m_state;
endpackage

// File: rtl/axis_master_if_if.sv
// AXI-Stream beat channel bundle; the transmitter uses the master modport.
interface axis_if;
  import axi_stream_pckg::*;

  logic [M_TDATA_WDT-1:0] tdata;
  logic                   tvalid;
  logic                   tlast;
  logic                   tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_master_if_fifo.sv
// Beat FIFO between the word unpacker and the output register; every entry is usable
// because the pointers carry an extra wrap bit.
module axis_m_fifo
  import axi_stream_pckg::*;
#(
  parameter int WDT = M_TDATA_WDT + 1,
  parameter int AW  = M_FIFO_ADDR_WDT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wr_en,
  input  logic [WDT-1:0] wr_data,
  input  logic           rd_en,
  output logic [WDT-1:0] rd_data,
  output logic           full,
  output logic           empty
);

  logic [WDT-1:0] mem [2**AW];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full)  wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty   = (wr_ptr == rd_ptr);

endmodule

// File: rtl/axis_master_if.sv
// Outbound AXI-Stream master: reads output-memory words, unpacks them MSB-first into
// beats, buffers them and drives a registered stream port with full backpressure.
module axis_master_if
  import dnn_pckg::*, axi_stream_pckg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  axis_if.master                        m_axis,
  output logic [ACTIV_MEM_ADDR_WDT-1:0] outputs_ext_mem_addr,
  output logic                          outputs_ext_mem_rd_en,
  input  logic [VLW_WDT-1:0]            outputs_ext_mem_data,
  input  logic                          outputs_tx_start,
  input  logic [ACTIV_MEM_ADDR_WDT:0]   outputs_num_words,
  input  logic                          comp_busy,
  input  logic                          inputs_rx_busy,
  output logic                          outputs_tx_busy,
  output logic                          outputs_tx_done
);

  localparam logic [ACTIV_MEM_ADDR_WDT:0] ONE_WORD  = (ACTIV_MEM_ADDR_WDT+1)'(1);
  localparam logic [BEAT_CNT_WDT-1:0]     LAST_BEAT = BEAT_CNT_WDT'(WORD_BEATS - 1);

  m_state                        state, state_nxt;
  logic                          start_ok, rd_issue;
  logic [ACTIV_MEM_ADDR_WDT:0]   words_left;
  logic [ACTIV_MEM_ADDR_WDT-1:0] rd_addr;
  logic                          rd_inflight, rd_inflight_last;
  logic [VLW_WDT-1:0]            pf_data;
  logic                          pf_valid, pf_last, pf_consume;
  logic [VLW_WDT-1:0]            unp_data;
  logic                          unp_valid, unp_last, unp_emit, unp_load, last_beat;
  logic [BEAT_CNT_WDT-1:0]       beat_cnt;
  logic [M_TDATA_WDT:0]          fifo_rd_data;
  logic                          fifo_full, fifo_empty, out_load;
  logic [M_TDATA_WDT-1:0]        tdata_q;
  logic                          tvalid_q, tlast_q, tlast_hs, done_q;

  assign start_ok   = (state == M_IDLE) && outputs_tx_start && !comp_busy &&
                      !inputs_rx_busy && (outputs_num_words != '0);
  assign last_beat  = (beat_cnt == LAST_BEAT);
  assign unp_emit   = unp_valid && !fifo_full;
  assign unp_load   = pf_valid && (!unp_valid || (unp_emit && last_beat));
  assign pf_consume = unp_load;
  assign out_load   = !fifo_empty && (!tvalid_q || m_axis.tready);
  assign tlast_hs   = tvalid_q && m_axis.tready && tlast_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= M_IDLE;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      done_q  <= (state == M_DRAIN) && tlast_hs;
    end
  end

  // One read at a time; the next is only issued once the prefetch slot will be free.
  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    case (state)
      M_IDLE: begin
        if (start_ok) state_nxt = M_SEND;
      end
      M_SEND: begin
        if ((words_left != '0) && !rd_inflight && (!pf_valid || pf_consume)) begin
          rd_issue = 1'b1;
          if (words_left == ONE_WORD) state_nxt = M_DRAIN;
        end
      end
      M_DRAIN: begin
        if (tlast_hs) state_nxt = M_IDLE;
      end
      default: state_nxt = M_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      words_left       <= '0;
      rd_addr          <= '0;
      rd_inflight      <= 1'b0;
      rd_inflight_last <= 1'b0;
    end else begin
      rd_inflight      <= rd_issue;
      rd_inflight_last <= rd_issue && (words_left == ONE_WORD);
      if (start_ok) begin
        words_left <= outputs_num_words;
        rd_addr    <= '0;
      end else if (rd_issue) begin
        words_left <= words_left - ONE_WORD;
        rd_addr    <= rd_addr + ACTIV_MEM_ADDR_WDT'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pf_data  <= '0;
      pf_valid <= 1'b0;
      pf_last  <= 1'b0;
    end else if (rd_inflight) begin
      pf_data  <= outputs_ext_mem_data;
      pf_valid <= 1'b1;
      pf_last  <= rd_inflight_last;
    end else if (pf_consume) begin
      pf_valid <= 1'b0;
    end
  end

  // Shifting left keeps the next beat in the top slice of the held word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      unp_data  <= '0;
      unp_valid <= 1'b0;
      unp_last  <= 1'b0;
      beat_cnt  <= '0;
    end else if (unp_load) begin
      unp_data  <= pf_data;
      unp_valid <= 1'b1;
      unp_last  <= pf_last;
      beat_cnt  <= '0;
    end else if (unp_emit) begin
      unp_data  <= unp_data << M_TDATA_WDT;
      beat_cnt  <= beat_cnt + BEAT_CNT_WDT'(1);
      if (last_beat) unp_valid <= 1'b0;
    end
  end

  axis_m_fifo #(
    .WDT (M_TDATA_WDT + 1),
    .AW  (M_FIFO_ADDR_WDT)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (unp_emit),
    .wr_data ({unp_last && last_beat, unp_data[VLW_WDT-1 -: M_TDATA_WDT]}),
    .rd_en   (out_load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (out_load) begin
      tdata_q  <= fifo_rd_data[M_TDATA_WDT-1:0];
      tlast_q  <= fifo_rd_data[M_TDATA_WDT];
      tvalid_q <= 1'b1;
    end else if (m_axis.tready) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  assign m_axis.tdata          = tdata_q;
  assign m_axis.tvalid         = tvalid_q;
  assign m_axis.tlast          = tlast_q;
  assign outputs_ext_mem_addr  = rd_addr;
  assign outputs_ext_mem_rd_en = rd_issue;
  assign outputs_tx_busy       = (state != M_IDLE);
  assign outputs_tx_done       = done_q;

endmodule

// File: tb/tb_axis_master_if.sv
// Directed bench for axis_master_if: a vector table of whole frames plus hand-written
// sequences for start-while-busy, back-to-back frames and reset mid-frame.
module tb_axis_master_if;
  import dnn_pckg::*;
  import axi_stream_pckg::*;

  typedef struct {
    logic [ACTIV_MEM_ADDR_WDT:0] num_words;
    logic                        comp_busy;
    logic                        rx_busy;
    int                          mode;       // 0 ready, 1 random ready, 2 long stall
    int                          exp_beats;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_if m_axis ();

  logic [ACTIV_MEM_ADDR_WDT-1:0] mem_addr;
  logic                          mem_rd_en;
  logic [VLW_WDT-1:0]            mem_data = '0;
  logic                          tx_start = 1'b0;
  logic [ACTIV_MEM_ADDR_WDT:0]   num_words = '0;
  logic                          comp_busy = 1'b0;
  logic                          rx_busy = 1'b0;
  logic                          tx_busy, tx_done;
  logic [VLW_WDT-1:0]            mem [256];

  axis_master_if dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .m_axis               (m_axis),
    .outputs_ext_mem_addr (mem_addr),
    .outputs_ext_mem_rd_en(mem_rd_en),
    .outputs_ext_mem_data (mem_data),
    .outputs_tx_start     (tx_start),
    .outputs_num_words    (num_words),
    .comp_busy            (comp_busy),
    .inputs_rx_busy       (rx_busy),
    .outputs_tx_busy      (tx_busy),
    .outputs_tx_done      (tx_done)
  );

  always @(posedge clk) if (mem_rd_en) mem_data <= mem[mem_addr];

  int checks = 0;
  int errors = 0;

  logic [31:0] beats[$];
  logic        lasts[$];
  int  cyc = 0, rd_cnt, done_cnt, done_cyc, last_hs_cyc, first_hs_cyc, first_rd_cyc, first_valid_cyc;
  bit  busy_seen, tvalid_seen, busy_at_done;
  bit  stall_pend = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearMonitor();
    beats.delete();
    lasts.delete();
    rd_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    first_hs_cyc = -1; first_rd_cyc = -1; first_valid_cyc = -1;
    busy_seen = 0; tvalid_seen = 0; busy_at_done = 0;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (stall_pend) begin
      checkOutput("hold_tvalid", 64'(m_axis.tvalid), 64'd1);
      checkOutput("hold_tdata", 64'(m_axis.tdata), 64'(stall_data));
      checkOutput("hold_tlast", 64'(m_axis.tlast), 64'(stall_last));
    end
    if (mem_rd_en) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (tx_busy) busy_seen = 1;
    if (m_axis.tvalid) begin
      tvalid_seen = 1;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = tx_busy;
    end
    if (m_axis.tvalid && m_axis.tready) begin
      beats.push_back(m_axis.tdata);
      lasts.push_back(m_axis.tlast);
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      last_hs_cyc = cyc;
    end
    stall_pend = m_axis.tvalid && !m_axis.tready && rst_n;
    stall_data = m_axis.tdata;
    stall_last = m_axis.tlast;
  end

  // Beat k of a frame starting at address 0 carries C0DE0000 + k.
  task automatic checkBeats(input string tag, input int exp_beats, input int frame_beats);
    checkOutput({tag, "_beat_count"}, 64'(beats.size()), 64'(exp_beats));
    for (int k = 0; k < beats.size() && k < exp_beats; k++) begin
      checkOutput({tag, "_tdata"}, 64'(beats[k]), 64'(32'hC0DE_0000 + (k % frame_beats)));
      checkOutput({tag, "_tlast"}, 64'(lasts[k]), 64'((k % frame_beats) == frame_beats - 1));
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int stall_cnt = 0;
    int rd_at_stall = -1;
    int beats_at_stall = -1;
    clearMonitor();
    @(posedge clk); #1;
    tx_start = 1'b1; num_words = v.num_words; comp_busy = v.comp_busy; rx_busy = v.rx_busy;
    m_axis.tready = (v.mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      tx_start = 1'b0; comp_busy = 1'b0; rx_busy = 1'b0;
      if (v.mode == 1) m_axis.tready = 1'($urandom_range(0, 1));
      else if (v.mode == 2 && beats.size() >= 1 && stall_cnt < 40) begin
        m_axis.tready = 1'b0;
        stall_cnt++;
        if (stall_cnt == 40) begin
          rd_at_stall = rd_cnt;
          beats_at_stall = beats.size();
        end
      end else m_axis.tready = 1'b1;
      if (done_cnt > 0 || (v.exp_beats == 0 && c >= 30)) break;
    end
    m_axis.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkBeats("frame", v.exp_beats, (v.exp_beats > 0) ? v.exp_beats : 1);
    if (v.exp_beats > 0) begin
      checkOutput("done_count", 64'(done_cnt), 64'd1);
      checkOutput("done_after_tlast", 64'(done_cyc - last_hs_cyc), 64'd1);
      checkOutput("busy_at_done", 64'(busy_at_done), 64'd0);
      checkOutput("read_count", 64'(rd_cnt), 64'(v.num_words));
      if (v.mode == 0) begin
        checkOutput("first_valid_latency", 64'(first_valid_cyc - first_rd_cyc), 64'd5);
        checkOutput("no_bubbles", 64'(last_hs_cyc - first_hs_cyc), 64'(v.exp_beats - 1));
      end
      if (v.mode == 2) begin
        checkOutput("stall_beats", 64'(beats_at_stall), 64'd1);
        checkOutput("stall_reads", 64'(rd_at_stall), 64'd4);
      end
    end else begin
      checkOutput("ignored_busy", 64'(busy_seen), 64'd0);
      checkOutput("ignored_tvalid", 64'(tvalid_seen), 64'd0);
      checkOutput("ignored_done", 64'(done_cnt), 64'd0);
      checkOutput("ignored_reads", 64'(rd_cnt), 64'd0);
    end
  endtask

  vec_t vecs[8];

  initial begin
    m_axis.tready = 1'b0;
    $display("[TB] vectors loaded, starting");
    vecs[0] = '{9'd3, 1'b0, 1'b0, 0, 12};
    vecs[1] = '{9'd3, 1'b0, 1'b0, 1, 12};
    vecs[2] = '{9'd6, 1'b0, 1'b0, 2, 24};
    vecs[3] = '{9'd1, 1'b0, 1'b0, 0, 4};
    vecs[4] = '{9'd0, 1'b0, 1'b0, 0, 0};
    vecs[5] = '{9'd3, 1'b1, 1'b0, 0, 0};
    vecs[6] = '{9'd3, 1'b0, 1'b1, 0, 0};
    vecs[7] = '{9'd5, 1'b0, 1'b0, 1, 20};
    for (int w = 0; w < 256; w++)
      for (int b = 0; b < WORD_BEATS; b++)
        mem[w][VLW_WDT-1-M_TDATA_WDT*b -: M_TDATA_WDT] = 32'hC0DE_0000 + 32'(w * WORD_BEATS + b);

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tvalid", 64'(m_axis.tvalid), 64'd0);
    checkOutput("reset_tlast", 64'(m_axis.tlast), 64'd0);
    checkOutput("reset_tdata", 64'(m_axis.tdata), 64'd0);
    checkOutput("reset_rd_en", 64'(mem_rd_en), 64'd0);
    checkOutput("reset_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset_busy", 64'(tx_busy), 64'd0);
    checkOutput("reset_done", 64'(tx_done), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // A start arriving mid-frame must not disturb the running frame.
    clearMonitor();
    @(posedge clk); #1;
    tx_start = 1'b1; num_words = 9'd3; m_axis.tready = 1'b1;
    for (int c = 0; c < 300 && done_cnt == 0; c++) begin
      @(posedge clk); #1;
      tx_start = (c == 3);
      num_words = (c == 3) ? 9'd1 : 9'd3;
    end
    tx_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkBeats("busy_start", 12, 12);
    checkOutput("busy_start_done", 64'(done_cnt), 64'd1);
    checkOutput("busy_start_reads", 64'(rd_cnt), 64'd3);

    // A start in the done cycle is accepted immediately.
    clearMonitor();
    @(posedge clk); #1;
    tx_start = 1'b1; num_words = 9'd1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (tx_done) begin
        tx_start = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    tx_start = 1'b0;
    for (int c = 0; c < 200 && done_cnt < 2; c++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    checkBeats("back2back", 8, 4);
    checkOutput("back2back_done", 64'(done_cnt), 64'd2);
    checkOutput("back2back_reads", 64'(rd_cnt), 64'd2);

    // Reset in the middle of a frame, then a fresh frame from address 0.
    clearMonitor();
    @(posedge clk); #1;
    tx_start = 1'b1; num_words = 9'd3;
    for (int c = 0; c < 200 && beats.size() < 5; c++) begin
      @(posedge clk); #1;
      tx_start = 1'b0;
    end
    checkOutput("pre_reset_beats", 64'(beats.size()), 64'd5);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_tvalid", 64'(m_axis.tvalid), 64'd0);
    checkOutput("midreset_busy", 64'(tx_busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clearMonitor();
    repeat (6) @(posedge clk);
    #1;
    checkOutput("midreset_no_done", 64'(done_cnt), 64'd0);
    applyStimulus('{9'd2, 1'b0, 1'b0, 0, 8});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
